multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Sequencing controller for the multicycle MIPS datapath. Decodes the latched instruction's `op`/`funct`, steps a Moore state machine through fetch, decode, execute, memory and writeback, and drives every datapath mux select and write enable each cycle. A `mem_ready` handshake lets the shared instruction/data memory insert wait states.

## Interface
Parameters:
- none; the opcode set is fixed by the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  6  opcode field of the instruction register
- `funct`  in  6  funct field of the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory access completes this cycle
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  register file write address select: 0 = rt, 1 = rd
- `memtoreg`  out  1  register write data select: 0 = ALUOut, 1 = Data
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU operand A select: 0 = PC, 1 = A
- `alusrcb`  out  2  ALU operand B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `pcsrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `pcen`  out  1  PC load enable
- `alucontrol`  out  3  ALU operation
- `state`  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: `alusrca`=0, `alusrcb`=01, aluop add, `pcsrc`=00, `iord`=0. `irwrite` and the PC write are asserted only when `mem_ready`=1. Go to DECODE when `mem_ready`=1; otherwise hold.
- DECODE: `alusrca`=0, `alusrcb`=11, aluop add (computes the branch target). Next state by `op`:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → RTYPEEX
  - beq 000100 → BEQEX
  - addi 001000 → ADDIEX
  - j 000010 → JEX
  - any other opcode → FETCH (executes as a NOP)
- MEMADR: `alusrca`=1, `alusrcb`=10, aluop add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1, then FETCH.
- MEMWR: `iord`=1, `memwrite`=1 for every cycle spent in the state. Go to FETCH on `mem_ready`.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, aluop funct, then RTYPEWB.
- RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1, then FETCH.
- BEQEX: `alusrca`=1, `alusrcb`=00, aluop sub, `pcsrc`=01, branch asserted, then FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10, aluop add, then ADDIWB.
- ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1, then FETCH.
- JEX: `pcsrc`=10, PC write asserted, then FETCH.
- Outputs decode from state only, except:
  - `pcen` = (pcwrite & gate) | (branch & `zero`)
  - FETCH write enables are gated by `mem_ready`.
- `alucontrol`: aluop 00 → 010 (add); 01 → 110 (sub); 10 decodes `funct`:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111
  - any other `funct` → 010
- Any don't-care select output is driven to 0.

## Timing
- Reset: the state register loads FETCH on the first rising edge with `reset`=1.
  - While `reset` is high, `irwrite`, `pcen`, `memwrite` and `regwrite` are forced to 0.
  - All other outputs hold their FETCH values; `state` = 0.
- `reset` asserted mid-instruction aborts it on that edge; no write enable fires during the reset cycle.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs are unchanged during a stall.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `op`, `funct` and `zero` are sampled combinationally in the state that uses them.

## Configuration
- `MULTICYCLE_ADDI_EN`
  - Defined: the ADDIEX and ADDIWB states exist and addi executes as above.
  - Undefined: those states are removed and opcode 001000 takes the illegal-opcode path (DECODE → FETCH, no register write).

## Structure
- Shared package `mips_mc_pkg`: state encoding (4-bit, FETCH = 0), opcode constants, aluop encodings, `alusrcb`/`pcsrc` encodings.
- One sub-module: the existing `aludec`, reused unchanged for the aluop/`funct` → `alucontrol` mapping. Next-state and output logic stay in this block.

## Test plan
- Reset mid-MEMWR with `mem_ready`=0 → `memwrite`=0 during the reset cycle; `state`=0 afterwards; the next FETCH proceeds normally.
- lw with `mem_ready`=1 → states 0,1,2,3,4; `regwrite`=1 only in cycle 5 with `memtoreg`=1, `regdst`=0. Repeat with `mem_ready` low for 2 cycles in FETCH and 3 in MEMRD → 10 cycles, `irwrite` pulses exactly once.
- sw with `mem_ready` low for 2 cycles → `memwrite`=1 for exactly 3 cycles, `iord`=1 throughout, `regwrite` never asserted.
- beq:
  - `zero`=1 in BEQEX → `pcen`=1 with `pcsrc`=01
  - `zero`=0 → `pcen`=0; 3 cycles either way
- R-type `funct`=101010 → `alucontrol`=111 in RTYPEEX; RTYPEWB asserts `regwrite`=1, `regdst`=1.
- `op`=001000:
  - with `MULTICYCLE_ADDI_EN` → 4 cycles and one `regwrite`
  - without it → 2 cycles and no `regwrite`
  - `op`=111111 → 2 cycles, no write enable asserted

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// MULTICYCLE_ADDI_EN adds the ADDIEX/ADDIWB states.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`endif
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: aluop plus funct to alucontrol.
// Unknown funct codes fall back to add.
module aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = 3'b010;
    unique case (aluop)
      ALUOP_ADD: alucontrol = 3'b010;
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_FN: begin
        unique case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencing controller (Moore FSM + aludec).
// MULTICYCLE_ADDI_EN enables native addi execution.
module multicycle_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t     state_q, nxt, cur;
  logic [1:0] aluop;
  logic       pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (state_q)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      nxt = ADDIEX;
`endif
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW)      nxt = MEMWR;
        else if (op == OP_LW) nxt = MEMRD;
        else                  nxt = FETCH;
      end
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      RTYPEEX: nxt = RTYPEWB;
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX:  nxt = ADDIWB;
`endif
      default: nxt = FETCH;
    endcase
  end

  // During reset the outputs present FETCH with every write disabled.
  assign cur   = reset ? FETCH : state_q;
  assign state = cur;

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: alusrcb = SRCB_IMMSH;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FN;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_OUT;
        branch  = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB: regwrite = 1'b1;
`endif
      JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction model.
// Define MULTICYCLE_ADDI_EN here too when the RTL is built with it.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

`ifdef MULTICYCLE_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2;
  localparam int S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
  localparam int S_RTEX = 6, S_RTWB = 7, S_BEQ = 8;
  localparam int S_ADDIEX = 9, S_ADDIWB = 10, S_JEX = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int alu_ref(input logic [5:0] f);
    int r;
    r = 2;
    if (f == 6'b100010) r = 6;
    if (f == 6'b100100) r = 0;
    if (f == 6'b100101) r = 1;
    if (f == 6'b101010) r = 7;
    return r;
  endfunction

  // Runs one instruction starting just after a rising edge in FETCH.
  // sf = FETCH wait states, sm = MEMRD/MEMWR wait states.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input logic iz, input int sf, input int sm);
    int  exp_st[$];
    bit  rdy[$];
    int  n_ir, n_reg, n_mw, n_pc, bad_iord, exp_reg, exp_pc;
    int  alu_seen, pcsrc_seen, m2r_seen, rd_seen;
    bit  is_addi;
    is_addi = (iop == ADDI) && ADDI_EN;
    for (int i = 0; i < sf; i++) begin
      exp_st.push_back(S_FETCH); rdy.push_back(1'b0);
    end
    exp_st.push_back(S_FETCH);  rdy.push_back(1'b1);
    exp_st.push_back(S_DECODE); rdy.push_back(1'($urandom_range(0, 1)));
    if (iop == LW || iop == SW) begin
      exp_st.push_back(S_MEMADR); rdy.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < sm; i++) begin
        exp_st.push_back(iop == LW ? S_MEMRD : S_MEMWR);
        rdy.push_back(1'b0);
      end
      exp_st.push_back(iop == LW ? S_MEMRD : S_MEMWR);
      rdy.push_back(1'b1);
      if (iop == LW) begin
        exp_st.push_back(S_MEMWB); rdy.push_back(1'($urandom_range(0, 1)));
      end
    end else if (iop == RT) begin
      exp_st.push_back(S_RTEX); rdy.push_back(1'($urandom_range(0, 1)));
      exp_st.push_back(S_RTWB); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (iop == BEQ) begin
      exp_st.push_back(S_BEQ); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (is_addi) begin
      exp_st.push_back(S_ADDIEX); rdy.push_back(1'($urandom_range(0, 1)));
      exp_st.push_back(S_ADDIWB); rdy.push_back(1'($urandom_range(0, 1)));
    end else if (iop == JMP) begin
      exp_st.push_back(S_JEX); rdy.push_back(1'($urandom_range(0, 1)));
    end
    n_ir = 0; n_reg = 0; n_mw = 0; n_pc = 0; bad_iord = 0;
    alu_seen = -1; pcsrc_seen = -1; m2r_seen = -1; rd_seen = -1;
    op = iop; funct = ifn; zero = iz;
    foreach (exp_st[i]) begin
      mem_ready = rdy[i];
      @(negedge clk);
      chk("state", int'(state), exp_st[i]);
      n_ir += int'(irwrite);
      n_mw += int'(memwrite);
      n_pc += int'(pcen);
      if (memwrite && !iord) bad_iord++;
      if (regwrite) begin
        n_reg++;
        m2r_seen = int'(memtoreg);
        rd_seen  = int'(regdst);
      end
      if (exp_st[i] == S_RTEX || exp_st[i] == S_BEQ)
        alu_seen = int'(alucontrol);
      if (exp_st[i] == S_BEQ || exp_st[i] == S_JEX)
        pcsrc_seen = int'(pcsrc);
      @(posedge clk);
      #1;
    end
    exp_reg = (iop == LW || iop == RT || is_addi) ? 1 : 0;
    exp_pc  = 1 + ((iop == JMP) ? 1 : 0) + ((iop == BEQ && iz) ? 1 : 0);
    chk("irwrite_count", n_ir, 1);
    chk("regwrite_count", n_reg, exp_reg);
    chk("memwrite_count", n_mw, (iop == SW) ? sm + 1 : 0);
    chk("pcen_count", n_pc, exp_pc);
    if (exp_reg == 1) begin
      chk("memtoreg", m2r_seen, (iop == LW) ? 1 : 0);
      chk("regdst", rd_seen, (iop == RT) ? 1 : 0);
    end
    if (iop == RT)  chk("alu_rtype", alu_seen, alu_ref(ifn));
    if (iop == BEQ) chk("alu_beq", alu_seen, 6);
    if (iop == BEQ) chk("pcsrc_beq", pcsrc_seen, 1);
    if (iop == JMP) chk("pcsrc_j", pcsrc_seen, 2);
    if (iop == SW)  chk("iord_sw", bad_iord, 0);
  endtask

  logic [5:0] ops [8];
  logic [5:0] fns [6];

  initial begin
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
    ops[4] = ADDI; ops[5] = JMP; ops[6] = BAD; ops[7] = 6'b000011;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000111;

    reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_irwrite", int'(irwrite), 0);
    chk("rst_pcen", int'(pcen), 0);
    chk("rst_alusrcb", int'(alusrcb), 1);
    chk("rst_iord", int'(iord), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset lands on a stalled MEMWR.
    op = SW; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_state", int'(state), S_MEMWR);
    chk("memwr_memwrite", int'(memwrite), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_memwrite", int'(memwrite), 0);
    chk("rst_mid_state", int'(state), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(LW, 6'd0, 1'b0, 0, 0);
    run_instr(LW, 6'd0, 1'b0, 2, 3);
    run_instr(SW, 6'd0, 1'b0, 0, 2);
    run_instr(BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(BEQ, 6'd0, 1'b0, 0, 0);
    run_instr(RT, 6'b101010, 1'b0, 0, 0);
    run_instr(ADDI, 6'd0, 1'b0, 0, 0);
    run_instr(BAD, 6'd0, 1'b0, 0, 0);
    run_instr(JMP, 6'd0, 1'b1, 1, 0);

    for (int k = 0; k < 60; k++) begin
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    @(negedge clk);
    chk("final_state", int'(state), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
